// File: rtl/control_pkg.sv
// Shared constants and state types for the BLE/local control arbiter.
package control_pkg;

   localparam logic [7:0] HDR_BYTE    = 8'hA5;
   localparam logic [7:0] CMD_PAN     = 8'h01;
   localparam logic [7:0] CMD_CHARGE  = 8'h02;
   localparam logic [7:0] CMD_NEWGAME = 8'h03;

   typedef enum logic [1:0] {IDLE, CMD, VAL, CHK} parse_state_t;
   typedef enum logic {LOCAL, REMOTE} owner_t;

   function automatic logic cmd_known(input logic [7:0] cmd);
      return (cmd == CMD_PAN) || (cmd == CMD_CHARGE) || (cmd == CMD_NEWGAME);
   endfunction

endpackage

// File: rtl/control_arbiter_if.sv
// Received-byte stream from uart_rx into the control arbiter.
interface control_arbiter_if;

   logic [7:0] byte_in;
   logic       byte_valid_in;

   modport master (output byte_in, output byte_valid_in);
   modport slave  (input  byte_in, input  byte_valid_in);

endinterface

// File: rtl/ble_packet_parser.sv
// Frames A5/cmd/val/chk packets from the UART byte stream, with an
// inter-byte timeout and a saturating bad-packet counter.
module ble_packet_parser
   import control_pkg::*;
#(
   parameter int BYTE_TIMEOUT = 2_000_000
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic [7:0] byte_in,
   input  logic       byte_valid_in,
   output logic       pkt_valid,
   output logic [7:0] pkt_cmd,
   output logic [7:0] pkt_val,
   output logic [7:0] err_count
);

   localparam int TW = $clog2(BYTE_TIMEOUT + 1);

   parse_state_t state, state_nxt;
   logic [TW-1:0] tmo_cnt;
   logic [7:0]    cmd_r, val_r;
   logic          bad_pkt;
   logic          timeout;
   logic          chk_ok;

   assign chk_ok  = (byte_in == (cmd_r ^ val_r)) && cmd_known(cmd_r);
   // A byte arriving on the expiry cycle still counts as in time.
   assign timeout = (state != IDLE) && !byte_valid_in && (tmo_cnt == TW'(BYTE_TIMEOUT));
   assign pkt_cmd = cmd_r;
   assign pkt_val = val_r;

   always_comb begin
      state_nxt = state;
      pkt_valid = 1'b0;
      bad_pkt   = 1'b0;
      if (byte_valid_in) begin
         case (state)
            IDLE: if (byte_in == HDR_BYTE) state_nxt = CMD;
            CMD:  state_nxt = VAL;
            VAL:  state_nxt = CHK;
            CHK: begin
               state_nxt = IDLE;
               if (chk_ok) pkt_valid = 1'b1;
               else        bad_pkt   = 1'b1;
            end
            default: state_nxt = IDLE;
         endcase
      end else if (timeout) begin
         state_nxt = IDLE;
         bad_pkt   = 1'b1;
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state     <= IDLE;
         tmo_cnt   <= '0;
         err_count <= '0;
      end else begin
         state <= state_nxt;
         if (byte_valid_in || state == IDLE)
            tmo_cnt <= '0;
         else if (tmo_cnt != TW'(BYTE_TIMEOUT))
            tmo_cnt <= tmo_cnt + TW'(1);
         if (bad_pkt && err_count != 8'hFF)
            err_count <= err_count + 8'd1;
      end
   end

   // Payload capture carries no control meaning, so it is left out of reset.
   always_ff @(posedge clk_in) begin
      if (byte_valid_in && state == CMD) cmd_r <= byte_in;
      if (byte_valid_in && state == VAL) val_r <= byte_in;
   end

endmodule

// File: rtl/control_arbiter.sv
// Chooses local vs. remote (BLE) gameplay controls with a frame lease and
// presents them to gameplay latched once per video frame.
module control_arbiter
   import control_pkg::*;
#(
   parameter int TIMEOUT_FRAMES = 30,
   parameter int BYTE_TIMEOUT   = 2_000_000
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   control_arbiter_if.slave     uart,
   input  logic                 new_frame_in,
   input  logic                 local_charge_in,
   input  logic                 local_pan_left_in,
   input  logic                 local_pan_right_in,
   input  logic                 local_override_in,
   output logic                 charging_hit_out,
   output logic                 pan_left_out,
   output logic                 pan_right_out,
   output logic                 new_game_out,
   output logic                 remote_owner_out,
   output logic [7:0]           err_count_out
);

   localparam int LW = $clog2(TIMEOUT_FRAMES + 1);

   logic          pkt_valid;
   logic [7:0]    pkt_cmd, pkt_val;
   owner_t        owner, owner_nxt;
   logic [LW-1:0] lease_cnt;
   logic          accept, lease_expire, enter_local, use_remote;
   logic          pend_charge, pend_left, pend_right;
   logic          src_charge, src_left, src_right;
   logic          unused_val_bits;

   ble_packet_parser #(.BYTE_TIMEOUT(BYTE_TIMEOUT)) u_parser (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .byte_in       (uart.byte_in),
      .byte_valid_in (uart.byte_valid_in),
      .pkt_valid     (pkt_valid),
      .pkt_cmd       (pkt_cmd),
      .pkt_val       (pkt_val),
      .err_count     (err_count_out)
   );

   assign unused_val_bits = &{1'b0, pkt_val[7:2]};

   // Override discards a valid packet silently: parsed, never applied.
   assign accept       = pkt_valid && !local_override_in;
   assign lease_expire = new_frame_in && (lease_cnt == LW'(TIMEOUT_FRAMES - 1));
   assign enter_local  = (owner == REMOTE) && (owner_nxt == LOCAL);

   always_comb begin
      owner_nxt = owner;
      case (owner)
         LOCAL:  if (accept) owner_nxt = REMOTE;
         REMOTE: begin
            if (local_override_in)          owner_nxt = LOCAL;
            else if (!accept && lease_expire) owner_nxt = LOCAL;
         end
         default: owner_nxt = LOCAL;
      endcase
   end

   assign use_remote = (owner == REMOTE) && !local_override_in;
   assign src_charge = use_remote ? pend_charge : local_charge_in;
   assign src_left   = use_remote ? pend_left   : local_pan_left_in;
   assign src_right  = use_remote ? pend_right  : local_pan_right_in;
   assign remote_owner_out = (owner == REMOTE);

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         owner            <= LOCAL;
         lease_cnt        <= '0;
         pend_charge      <= 1'b0;
         pend_left        <= 1'b0;
         pend_right       <= 1'b0;
         new_game_out     <= 1'b0;
         charging_hit_out <= 1'b0;
         pan_left_out     <= 1'b0;
         pan_right_out    <= 1'b0;
      end else begin
         owner        <= owner_nxt;
         new_game_out <= accept && (pkt_cmd == CMD_NEWGAME);

         if (owner_nxt != REMOTE || accept) lease_cnt <= '0;
         else if (new_frame_in)             lease_cnt <= lease_cnt + LW'(1);

         if (accept) begin
            case (pkt_cmd)
               CMD_PAN: begin
                  pend_left  <= pkt_val[0];
                  pend_right <= pkt_val[1];
               end
               CMD_CHARGE: pend_charge <= pkt_val[0];
               default: ;
            endcase
         end else if (enter_local) begin
            pend_charge <= 1'b0;
            pend_left   <= 1'b0;
            pend_right  <= 1'b0;
         end

         // Opposing pan requests cancel rather than pick a side.
         if (new_frame_in) begin
            charging_hit_out <= src_charge;
            pan_left_out     <= src_left & ~src_right;
            pan_right_out    <= src_right & ~src_left;
         end
      end
   end

endmodule

// File: tb/tb_control_arbiter.sv
// Directed bench for control_arbiter with small lease and byte timeouts.
module tb_control_arbiter;

   logic       clk_in = 1'b0;
   logic       rst_in = 1'b1;
   logic       new_frame_in = 1'b0;
   logic       local_charge_in = 1'b0;
   logic       local_pan_left_in = 1'b0;
   logic       local_pan_right_in = 1'b0;
   logic       local_override_in = 1'b0;
   logic       charging_hit_out, pan_left_out, pan_right_out;
   logic       new_game_out, remote_owner_out;
   logic [7:0] err_count_out;

   int total = 0;
   int bad   = 0;

   control_arbiter_if uart ();

   control_arbiter #(.TIMEOUT_FRAMES(3), .BYTE_TIMEOUT(20)) dut (
      .clk_in             (clk_in),
      .rst_in             (rst_in),
      .uart               (uart.slave),
      .new_frame_in       (new_frame_in),
      .local_charge_in    (local_charge_in),
      .local_pan_left_in  (local_pan_left_in),
      .local_pan_right_in (local_pan_right_in),
      .local_override_in  (local_override_in),
      .charging_hit_out   (charging_hit_out),
      .pan_left_out       (pan_left_out),
      .pan_right_out      (pan_right_out),
      .new_game_out       (new_game_out),
      .remote_owner_out   (remote_owner_out),
      .err_count_out      (err_count_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk_in);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic with_frame);
      @(negedge clk_in);
      uart.byte_in       = b;
      uart.byte_valid_in = 1'b1;
      new_frame_in       = with_frame;
      @(negedge clk_in);
      uart.byte_valid_in = 1'b0;
      new_frame_in       = 1'b0;
   endtask

   task automatic send_pkt(input logic [7:0] c, input logic [7:0] v, input logic [7:0] k);
      send_byte(8'hA5, 1'b0);
      send_byte(c, 1'b0);
      send_byte(v, 1'b0);
      send_byte(k, 1'b0);
   endtask

   task automatic frame();
      @(negedge clk_in);
      new_frame_in = 1'b1;
      @(negedge clk_in);
      new_frame_in = 1'b0;
   endtask

   initial begin
      uart.byte_in       = 8'h00;
      uart.byte_valid_in = 1'b0;
      idle(3);
      check_val("rst_charge", charging_hit_out, 1'b0);
      check_val("rst_left", pan_left_out, 1'b0);
      check_val("rst_right", pan_right_out, 1'b0);
      check_val("rst_newgame", new_game_out, 1'b0);
      check_val("rst_owner", remote_owner_out, 1'b0);
      check_val("rst_err", err_count_out, 8'd0);
      rst_in = 1'b0;
      idle(2);

      // Remote PAN left takes ownership; outputs wait for the frame.
      send_pkt(8'h01, 8'h01, 8'h00);
      check_val("pan_owner_t1", remote_owner_out, 1'b1);
      check_val("pan_left_prefr", pan_left_out, 1'b0);
      frame();
      check_val("pan_left", pan_left_out, 1'b1);
      check_val("pan_right", pan_right_out, 1'b0);
      check_val("pan_owner", remote_owner_out, 1'b1);

      // Bad checksum.
      send_pkt(8'h02, 8'h01, 8'h07);
      idle(1);
      check_val("badchk_err", err_count_out, 8'd1);
      check_val("badchk_owner", remote_owner_out, 1'b1);
      check_val("badchk_left", pan_left_out, 1'b1);
      check_val("badchk_charge", charging_hit_out, 1'b0);

      // CHARGE with checksum on the frame cycle: old value latched first.
      send_byte(8'hA5, 1'b0);
      send_byte(8'h02, 1'b0);
      send_byte(8'h01, 1'b0);
      send_byte(8'h03, 1'b1);
      check_val("samefr_charge", charging_hit_out, 1'b0);
      check_val("samefr_left", pan_left_out, 1'b1);
      frame();
      check_val("nextfr_charge", charging_hit_out, 1'b1);
      frame();
      // Packet clear coincides with the lease-expiring frame: clear wins.
      send_byte(8'hA5, 1'b0);
      send_byte(8'h01, 1'b0);
      send_byte(8'h02, 1'b0);
      send_byte(8'h03, 1'b1);
      idle(2);
      check_val("clearwins_owner", remote_owner_out, 1'b1);
      check_val("clearwins_left_old", pan_left_out, 1'b1);
      frame();
      check_val("clearwins_left", pan_left_out, 1'b0);
      check_val("clearwins_right", pan_right_out, 1'b1);

      // Lease expiry after three frames with no packets.
      local_pan_left_in = 1'b1;
      send_pkt(8'h02, 8'h00, 8'h02);
      frame();
      check_val("lease_f1_owner", remote_owner_out, 1'b1);
      check_val("lease_f1_charge", charging_hit_out, 1'b0);
      frame();
      idle(2);
      check_val("lease_f2_owner", remote_owner_out, 1'b1);
      frame();
      idle(2);
      check_val("lease_f3_owner", remote_owner_out, 1'b0);
      frame();
      check_val("lease_local_left", pan_left_out, 1'b1);
      check_val("lease_local_right", pan_right_out, 1'b0);

      // Stray byte in IDLE, then an aborted packet, then NEWGAME.
      send_byte(8'h55, 1'b0);
      idle(1);
      check_val("stray_err", err_count_out, 8'd1);
      send_byte(8'hA5, 1'b0);
      send_byte(8'h01, 1'b0);
      idle(30);
      check_val("tmo_err", err_count_out, 8'd2);
      send_pkt(8'h03, 8'h00, 8'h03);
      check_val("ng_pulse", new_game_out, 1'b1);
      idle(1);
      check_val("ng_pulse_end", new_game_out, 1'b0);
      check_val("ng_err", err_count_out, 8'd2);

      // Override drops REMOTE and swallows a valid packet.
      local_override_in  = 1'b1;
      local_charge_in    = 1'b1;
      local_pan_right_in = 1'b1;
      idle(2);
      check_val("ovr_owner_now", remote_owner_out, 1'b0);
      send_pkt(8'h01, 8'h02, 8'h03);
      check_val("ovr_owner", remote_owner_out, 1'b0);
      check_val("ovr_newgame", new_game_out, 1'b0);
      idle(1);
      check_val("ovr_err", err_count_out, 8'd2);
      frame();
      check_val("ovr_charge", charging_hit_out, 1'b1);
      check_val("ovr_both_left", pan_left_out, 1'b0);
      check_val("ovr_both_right", pan_right_out, 1'b0);

      // Error counter saturates.
      for (int i = 0; i < 260; i++) send_pkt(8'h02, 8'h01, 8'h07);
      idle(1);
      check_val("err_sat", err_count_out, 8'd255);

      // Asynchronous reset in the middle of a packet.
      local_override_in  = 1'b0;
      local_charge_in    = 1'b0;
      local_pan_left_in  = 1'b0;
      local_pan_right_in = 1'b0;
      send_pkt(8'h02, 8'h01, 8'h03);
      frame();
      check_val("pre_rst_charge", charging_hit_out, 1'b1);
      check_val("pre_rst_owner", remote_owner_out, 1'b1);
      send_byte(8'hA5, 1'b0);
      send_byte(8'h01, 1'b0);
      #2 rst_in = 1'b1;
      #1;
      check_val("arst_charge", charging_hit_out, 1'b0);
      check_val("arst_owner", remote_owner_out, 1'b0);
      check_val("arst_err", err_count_out, 8'd0);
      idle(2);
      rst_in = 1'b0;
      send_byte(8'h01, 1'b0);
      send_byte(8'h00, 1'b0);
      idle(1);
      check_val("post_rst_owner", remote_owner_out, 1'b0);
      check_val("post_rst_err", err_count_out, 8'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
